// File: rtl/ph_reg3_sync_pkg.sv
// Shared Tube constants for the parasite-to-host register 3 FIFO.
// Holds the mode encoding and reset data value used by ph_reg3_sync.
package ph_reg3_sync_pkg;

  localparam logic ONE_BYTE = 1'b1;
  localparam logic TWO_BYTE = 1'b0;

  localparam logic [7:0] REG3_RESET_DATA = 8'h00;

  // One-byte mode tracks the first slot; two-byte mode tracks completion of the pair.
  function automatic logic pair_flag(input logic mode, input logic f0, input logic f1);
    pair_flag = (mode == ONE_BYTE) ? f0 : f1;
  endfunction

endpackage

// File: rtl/ph_reg3_flag.sv
// Single valid flag for one register 3 FIFO slot.
// Clear has priority so a mode flush always empties the slot.
module ph_reg3_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Slot valid state.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ph_reg3_sync.sv
// Parasite-to-host register 3 FIFO (2 bytes), both Tube sides on one clock.
// Define PH_REG3_ERR_EN to add sticky p_overrun/h_underrun flags and err_clr.
module ph_reg3_sync
  import ph_reg3_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       p_phi2_en,
  input  logic       p_selectData,
  input  logic       p_rdnw,
  input  logic [7:0] p_data,
  input  logic       h_phi2_en,
  input  logic       h_selectData,
  input  logic       h_rdnw,
  input  logic       one_byte_mode,
  output logic [7:0] h_data,
  output logic       h_data_available,
  output logic       p_full
`ifdef PH_REG3_ERR_EN
  ,
  input  logic       err_clr,
  output logic       p_overrun,
  output logic       h_underrun
`endif
);

  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       f0;
  logic       f1;
  logic       mode_q;

  logic wr_ev;
  logic rd_ev;
  logic mode_chg;
  logic is_two;
  logic pair_ready;
  logic wr_ok;
  logic rd_ok;
  logic load0;
  logic load1;
  logic clr0;
  logic clr1;

  assign wr_ev = p_phi2_en & p_selectData & ~p_rdnw;
  assign rd_ev = h_phi2_en & h_selectData & h_rdnw;

  // Full and available are the same flag, so a write and a read can never both be accepted.
  always_comb begin
    mode_chg   = (one_byte_mode != mode_q);
    is_two     = (one_byte_mode == TWO_BYTE);
    pair_ready = pair_flag(one_byte_mode, f0, f1);
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;
    load0      = 1'b0;
    load1      = 1'b0;
    clr0       = 1'b0;
    clr1       = 1'b0;
    if (mode_chg) begin
      clr0 = 1'b1;
      clr1 = 1'b1;
    end else begin
      wr_ok = wr_ev & ~pair_ready;
      rd_ok = rd_ev & pair_ready;
      load0 = wr_ok & ~f0;
      load1 = wr_ok & f0 & is_two;
      clr0  = rd_ok & f0;
      clr1  = rd_ok & ~f0 & is_two;
    end
  end

  ph_reg3_flag u_flag0 (
    .clk (clk),
    .rst (rst),
    .set (load0),
    .clr (clr0),
    .q   (f0)
  );

  ph_reg3_flag u_flag1 (
    .clk (clk),
    .rst (rst),
    .set (load1),
    .clr (clr1),
    .q   (f1)
  );

  // Byte storage and registered mode; bytes survive a mode flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte0  <= REG3_RESET_DATA;
      byte1  <= REG3_RESET_DATA;
      mode_q <= one_byte_mode;
    end else begin
      mode_q <= one_byte_mode;
      if (load0) begin
        byte0 <= p_data;
      end else begin
        byte0 <= byte0;
      end
      if (load1) begin
        byte1 <= p_data;
      end else begin
        byte1 <= byte1;
      end
    end
  end

  // The second byte is only presented once the first has been consumed.
  always_comb begin
    if (is_two && !f0 && f1) begin
      h_data = byte1;
    end else begin
      h_data = byte0;
    end
  end

  assign h_data_available = pair_ready;
  assign p_full           = pair_ready;

`ifdef PH_REG3_ERR_EN
  logic overrun_set;
  logic underrun_set;

  assign overrun_set  = wr_ev & ~mode_chg & pair_ready;
  assign underrun_set = rd_ev & ~mode_chg & ~pair_ready;

  // Sticky error flags; a new error beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_overrun  <= 1'b0;
      h_underrun <= 1'b0;
    end else begin
      if (overrun_set) begin
        p_overrun <= 1'b1;
      end else if (err_clr) begin
        p_overrun <= 1'b0;
      end else begin
        p_overrun <= p_overrun;
      end
      if (underrun_set) begin
        h_underrun <= 1'b1;
      end else if (err_clr) begin
        h_underrun <= 1'b0;
      end else begin
        h_underrun <= h_underrun;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ph_reg3_sync.sv
// Directed self-checking bench for ph_reg3_sync; error-flag checks follow PH_REG3_ERR_EN.
module tb_ph_reg3_sync;

  logic       clk;
  logic       rst;
  logic       p_phi2_en;
  logic       p_selectData;
  logic       p_rdnw;
  logic [7:0] p_data;
  logic       h_phi2_en;
  logic       h_selectData;
  logic       h_rdnw;
  logic       one_byte_mode;
  logic [7:0] h_data;
  logic       h_data_available;
  logic       p_full;
`ifdef PH_REG3_ERR_EN
  logic       err_clr;
  logic       p_overrun;
  logic       h_underrun;
`endif

  int n_cmp;
  int n_err;

  ph_reg3_sync dut (
    .clk              (clk),
    .rst              (rst),
    .p_phi2_en        (p_phi2_en),
    .p_selectData     (p_selectData),
    .p_rdnw           (p_rdnw),
    .p_data           (p_data),
    .h_phi2_en        (h_phi2_en),
    .h_selectData     (h_selectData),
    .h_rdnw           (h_rdnw),
    .one_byte_mode    (one_byte_mode),
    .h_data           (h_data),
    .h_data_available (h_data_available),
    .p_full           (p_full)
`ifdef PH_REG3_ERR_EN
    ,
    .err_clr          (err_clr),
    .p_overrun        (p_overrun),
    .h_underrun       (h_underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clk with optional parasite write and host read strobes; samples settle #1 after the edge.
  task automatic bus(input logic wr, input logic rd, input logic [7:0] d);
    p_phi2_en    = wr;
    p_selectData = wr;
    p_rdnw       = 1'b0;
    p_data       = d;
    h_phi2_en    = rd;
    h_selectData = rd;
    h_rdnw       = 1'b1;
    @(posedge clk);
    #1;
    p_phi2_en    = 1'b0;
    p_selectData = 1'b0;
    h_phi2_en    = 1'b0;
    h_selectData = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic flag);
    check_eq({tag, "_data"}, h_data, d);
    check_eq({tag, "_avail"}, {7'd0, h_data_available}, {7'd0, flag});
    check_eq({tag, "_full"}, {7'd0, p_full}, {7'd0, flag});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    p_phi2_en = 1'b0; p_selectData = 1'b0; p_rdnw = 1'b1; p_data = 8'h00;
    h_phi2_en = 1'b0; h_selectData = 1'b0; h_rdnw = 1'b0;
    one_byte_mode = 1'b0;
`ifdef PH_REG3_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset", 8'h00, 1'b0);

    // Two-byte mode: flags only on a complete pair.
    bus(1'b1, 1'b0, 8'hA5);
    check_state("wr1", 8'hA5, 1'b0);
    bus(1'b1, 1'b0, 8'h5A);
    check_state("wr2", 8'hA5, 1'b1);
    bus(1'b0, 1'b1, 8'h00);
    check_state("rd1", 8'h5A, 1'b1);
    bus(1'b0, 1'b1, 8'h00);
    check_state("rd2", 8'hA5, 1'b0);

    // Empty read: underrun, no state change.
    bus(1'b0, 1'b1, 8'h00);
    check_state("empty_rd", 8'hA5, 1'b0);
`ifdef PH_REG3_ERR_EN
    check_eq("underrun_set", {7'd0, h_underrun}, 8'h01);
    err_clr = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    check_eq("underrun_clr", {7'd0, h_underrun}, 8'h00);
`endif

    // Strobe gating: phi2 low or select low does nothing.
    p_selectData = 1'b1; p_rdnw = 1'b0; p_data = 8'hEE; p_phi2_en = 1'b0;
    @(posedge clk); #1;
    p_selectData = 1'b0; p_phi2_en = 1'b1;
    @(posedge clk); #1;
    p_phi2_en = 1'b0;
    check_state("no_strobe", 8'hA5, 1'b0);

    // Simultaneous events: exactly one of write/read takes effect.
    bus(1'b1, 1'b1, 8'h11);
    check_state("sim1", 8'h11, 1'b0);
    bus(1'b1, 1'b1, 8'h22);
    check_state("sim2", 8'h11, 1'b1);
    bus(1'b1, 1'b1, 8'h33);
    check_state("sim3", 8'h22, 1'b1);
`ifdef PH_REG3_ERR_EN
    check_eq("sim3_ovr", {7'd0, p_overrun}, 8'h01);
    err_clr = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    check_eq("ovr_clr", {7'd0, p_overrun}, 8'h00);
`endif
    bus(1'b0, 1'b1, 8'h00);
    check_state("sim_drain", 8'h11, 1'b0);

    // One-byte mode: single latch.
    one_byte_mode = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    bus(1'b1, 1'b0, 8'h3C);
    check_state("ob_wr", 8'h3C, 1'b1);
    bus(1'b1, 1'b0, 8'hFF);
    check_state("ob_drop", 8'h3C, 1'b1);
`ifdef PH_REG3_ERR_EN
    check_eq("ob_ovr", {7'd0, p_overrun}, 8'h01);
`endif
    bus(1'b0, 1'b1, 8'h00);
    check_state("ob_rd", 8'h3C, 1'b0);

    // Mode switch with f0 set: flush, and the coincident write is ignored.
    bus(1'b1, 1'b0, 8'h77);
    check_state("pre_sw", 8'h77, 1'b1);
    one_byte_mode = 1'b0;
    bus(1'b1, 1'b0, 8'h88);
    check_state("switch", 8'h77, 1'b0);
    bus(1'b1, 1'b0, 8'h99);
    bus(1'b1, 1'b0, 8'h66);
    check_state("post_sw", 8'h99, 1'b1);
    bus(1'b0, 1'b1, 8'h00);
    check_state("post_sw_rd", 8'h66, 1'b1);
    bus(1'b0, 1'b1, 8'h00);

    // Reset mid-pair drops the partial byte.
    bus(1'b1, 1'b0, 8'h44);
    check_state("mid_pair", 8'h44, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_state("mid_rst", 8'h00, 1'b0);
    bus(1'b1, 1'b0, 8'h55);
    check_state("after_rst", 8'h55, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
